// File: rtl/hybrid_result_serializer_if.sv
// Sample stream from the result serializer to the downstream sink.
// Handshake: a beat moves on a rising edge where s_valid && s_ready; while s_valid is high and
// s_ready is low the producer holds s_real/s_imag/s_index/s_last stable.
interface hybrid_result_serializer_if #(parameter int DW = 12);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_real;
  logic [DW-1:0] s_imag;
  logic [2:0]    s_index;
  logic          s_last;

  modport master (output s_valid, s_real, s_imag, s_index, s_last, input s_ready);
  modport slave  (input s_valid, s_real, s_imag, s_index, s_last, output s_ready);
endinterface

// File: rtl/hybrid_result_serializer.sv
// Captures one 8-point complex result frame from HybridCore and streams it one sample per beat.
// Optional macro TWOS_COMP_OUT_EN converts sign-magnitude output samples to two's complement.
module hybrid_result_serializer #(
  parameter int DW     = 12,
  parameter bit BITREV = 1'b0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          load,
  input  logic [DW-1:0] rO0, rO1, rO2, rO3, rO4, rO5, rO6, rO7,
  input  logic [DW-1:0] iO0, iO1, iO2, iO3, iO4, iO5, iO6, iO7,
  hybrid_result_serializer_if.master sOut,
  output logic          busy,
  output logic          overrun,
  output logic          dbgState
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state, nextState;
  logic [2:0]    cnt, nextCnt, sIdx;
  logic          capture, setOverrun;
  logic [DW-1:0] inR [8];
  logic [DW-1:0] inI [8];
  logic [DW-1:0] bufR [8];
  logic [DW-1:0] bufI [8];

  assign inR = '{rO0, rO1, rO2, rO3, rO4, rO5, rO6, rO7};
  assign inI = '{iO0, iO1, iO2, iO3, iO4, iO5, iO6, iO7};

  function automatic logic [DW-1:0] fmtSample(input logic [DW-1:0] w);
`ifdef TWOS_COMP_OUT_EN
    // Negative zero falls out naturally: -0 == 0.
    if (w[DW-1]) return -{1'b0, w[DW-2:0]};
    else         return w;
`else
    return w;
`endif
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_comb begin
    nextState  = state;
    nextCnt    = cnt;
    capture    = 1'b0;
    setOverrun = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture   = 1'b1;
          nextCnt   = 3'd0;
          nextState = STREAM;
        end
      end
      STREAM: begin
        if (sOut.s_ready) nextCnt = cnt + 3'd1;
        // A load coinciding with the final transfer chains the next frame without a bubble.
        if (sOut.s_ready && cnt == 3'd7) begin
          if (load) begin
            capture = 1'b1;
            nextCnt = 3'd0;
          end else begin
            nextState = IDLE;
          end
        end else if (load) begin
          setOverrun = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < 8; k++) begin
        bufR[k] <= '0;
        bufI[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < 8; k++) begin
        bufR[k] <= inR[k];
        bufI[k] <= inI[k];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)           overrun <= 1'b0;
    else if (setOverrun) overrun <= 1'b1;
  end

  assign sIdx = BITREV ? {cnt[0], cnt[1], cnt[2]} : cnt;

  always_comb begin
    sOut.s_valid = 1'b0;
    sOut.s_real  = '0;
    sOut.s_imag  = '0;
    sOut.s_index = 3'd0;
    sOut.s_last  = 1'b0;
    if (state == STREAM) begin
      sOut.s_valid = 1'b1;
      sOut.s_real  = fmtSample(bufR[sIdx]);
      sOut.s_imag  = fmtSample(bufI[sIdx]);
      sOut.s_index = sIdx;
      sOut.s_last  = (cnt == 3'd7);
    end
  end

  assign busy     = (state == STREAM);
  assign dbgState = (state == STREAM);

endmodule
